// File: rtl/bound_flasher_ctrl.sv
// Purpose : sequencing controller for the 16-lamp bound flasher (on/off lamp walk with kickback at lamp 5 / lamp 10).
// Latency : one div_clk edge per lamp step; cur_st, lamps and seq_done are all registered.
// Backpressure: none; flick is level-sampled on every div_clk edge and only acted on in ST_INITIAL or at the kickback points.
//
// Ports:
//   div_clk  - divided system clock, all state updates on its rising edge
//   rst      - asynchronous, active-high reset
//   flick    - start / kickback request
//   cur_st   - current controller state
//   lamps    - thermometer-coded lamp drive, bit i = lamp i
//   seq_done - one-cycle pulse on the edge that returns to ST_INITIAL
module bound_flasher_ctrl #(
    parameter int N_LAMPS    = 16,
    parameter int LOW_BOUND  = 6,
    parameter int MID_BOUND  = 11,
    parameter int REST_BOUND = 5
) (
    input  logic               div_clk,
    input  logic               rst,
    input  logic               flick,
    output logic [2:0]         cur_st,
    output logic [N_LAMPS-1:0] lamps,
    output logic               seq_done
);

    typedef enum logic [2:0] {
        ST_INITIAL = 3'd0,
        ST_ON_5    = 3'd1,
        ST_OFF_0   = 3'd2,
        ST_ON_10   = 3'd3,
        ST_OFF_5   = 3'd4,
        ST_ON_15   = 3'd5,
        ST_OFF_ALL = 3'd6
    } state_t;

    // Boundary patterns: the lamp values at which the walk changes direction.
    localparam logic [N_LAMPS-1:0] LOW_PAT  = {{(N_LAMPS-LOW_BOUND){1'b0}},  {LOW_BOUND{1'b1}}};
    localparam logic [N_LAMPS-1:0] MID_PAT  = {{(N_LAMPS-MID_BOUND){1'b0}},  {MID_BOUND{1'b1}}};
    localparam logic [N_LAMPS-1:0] REST_PAT = {{(N_LAMPS-REST_BOUND){1'b0}}, {REST_BOUND{1'b1}}};
    localparam logic [N_LAMPS-1:0] FULL_PAT = {N_LAMPS{1'b1}};
    localparam logic [N_LAMPS-1:0] ZERO_PAT = {N_LAMPS{1'b0}};
    localparam logic [N_LAMPS-1:0] ONE_PAT  = {{(N_LAMPS-1){1'b0}}, 1'b1};

    state_t             state_nxt;
    logic [N_LAMPS-1:0] lamps_nxt;
    logic               done_nxt;
    logic [N_LAMPS-1:0] on_step;
    logic [N_LAMPS-1:0] off_step;
    logic               lamps_ok;

    assign on_step  = {lamps[N_LAMPS-2:0], 1'b1};
    assign off_step = {1'b0, lamps[N_LAMPS-1:1]};

    // A thermometer code plus one is a power of two, so it shares no set bit
    // with the original value; any gap in the ones breaks this.
    assign lamps_ok = ((lamps & (lamps + ONE_PAT)) == ZERO_PAT);

    // Transitions compare against lamps_nxt so the state flips on the same
    // edge that writes the boundary value.
    always_comb begin
        state_nxt = state_t'(cur_st);
        lamps_nxt = lamps;
        done_nxt  = 1'b0;

        if (cur_st == 3'd7 || !lamps_ok) begin
            // Corrupted register contents: resynchronise to idle.
            state_nxt = ST_INITIAL;
            lamps_nxt = ZERO_PAT;
        end else begin
            case (state_t'(cur_st))
                ST_INITIAL: begin
                    lamps_nxt = ZERO_PAT;
                    if (flick) state_nxt = ST_ON_5;
                end
                ST_ON_5: begin
                    lamps_nxt = on_step;
                    if (on_step == LOW_PAT) state_nxt = ST_OFF_0;
                end
                ST_OFF_0: begin
                    lamps_nxt = off_step;
                    if (off_step == ZERO_PAT) state_nxt = ST_ON_10;
                end
                ST_ON_10: begin
                    lamps_nxt = on_step;
                    // Kickback to zero at either bound while flick is high.
                    if (on_step == LOW_PAT && flick) begin
                        state_nxt = ST_OFF_0;
                    end else if (on_step == MID_PAT) begin
                        state_nxt = flick ? ST_OFF_0 : ST_OFF_5;
                    end
                end
                ST_OFF_5: begin
                    lamps_nxt = off_step;
                    if (off_step == REST_PAT) state_nxt = ST_ON_15;
                end
                ST_ON_15: begin
                    lamps_nxt = on_step;
                    if (on_step == MID_PAT && flick) begin
                        state_nxt = ST_OFF_5;
                    end else if (on_step == FULL_PAT) begin
                        state_nxt = ST_OFF_ALL;
                    end
                end
                ST_OFF_ALL: begin
                    lamps_nxt = off_step;
                    if (off_step == ZERO_PAT) begin
                        state_nxt = ST_INITIAL;
                        done_nxt  = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_INITIAL;
                    lamps_nxt = ZERO_PAT;
                end
            endcase
        end
    end

    always_ff @(posedge div_clk or posedge rst) begin
        if (rst) begin
            cur_st   <= ST_INITIAL;
            lamps    <= ZERO_PAT;
            seq_done <= 1'b0;
        end else begin
            cur_st   <= state_nxt;
            lamps    <= lamps_nxt;
            seq_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
module tb_bound_flasher_ctrl;

    logic        div_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        flick   = 1'b0;
    logic [2:0]  cur_st;
    logic [15:0] lamps;
    logic        seq_done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 div_clk = ~div_clk;

    bound_flasher_ctrl dut (
        .div_clk  (div_clk),
        .rst      (rst),
        .flick    (flick),
        .cur_st   (cur_st),
        .lamps    (lamps),
        .seq_done (seq_done)
    );

    typedef struct {
        logic        flick;
        logic [2:0]  st;
        logic [15:0] lamps;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] therm(input int n);
        logic [31:0] v;
        v = (32'd1 << n) - 32'd1;
        return v[15:0];
    endfunction

    function automatic void add(input logic f, input logic [2:0] st, input logic [15:0] l, input logic d);
        vec_t v;
        v.flick = f; v.st = st; v.lamps = l; v.done = d;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [2:0] st, input logic [15:0] l, input logic d);
        n_cmp++;
        if (cur_st !== st || lamps !== l || seq_done !== d) begin
            n_fail++;
            $display("FAIL %s: got st=%0d lamps=%h done=%b, want st=%0d lamps=%h done=%b",
                     name, cur_st, lamps, seq_done, st, l, d);
        end
    endtask

    // Called at a negedge: drive flick, take one rising edge, check at the next negedge.
    task automatic step(input string name, input logic f, input logic [2:0] st, input logic [15:0] l, input logic d);
        flick = f;
        @(posedge div_clk);
        @(negedge div_clk);
        check(name, st, l, d);
    endtask

    // Step with flick low until the given state/lamps are visible, bounded.
    task automatic advance_to(input string name, input logic [2:0] st, input logic [15:0] l);
        bit hit = 0;
        flick = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge div_clk);
            @(negedge div_clk);
            if (cur_st === st && lamps === l) hit = 1;
        end
        n_cmp++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: timeout, got st=%0d lamps=%h, want st=%0d lamps=%h", name, cur_st, lamps, st, l);
        end
    endtask

    task automatic start_seq(input string name);
        step(name, 1'b1, 3'd1, 16'h0000, 1'b0);
        flick = 1'b0;
    endtask

    initial begin
        // Full sequence table: flick pulsed once, then low for 57 edges total.
        add(1'b1, 3'd1, 16'h0000, 1'b0);
        for (int i = 1; i <= 6; i++)   add(1'b0, (i == 6)  ? 3'd2 : 3'd1, therm(i), 1'b0);
        for (int i = 5; i >= 0; i--)   add(1'b0, (i == 0)  ? 3'd3 : 3'd2, therm(i), 1'b0);
        for (int i = 1; i <= 11; i++)  add(1'b0, (i == 11) ? 3'd4 : 3'd3, therm(i), 1'b0);
        for (int i = 10; i >= 5; i--)  add(1'b0, (i == 5)  ? 3'd5 : 3'd4, therm(i), 1'b0);
        for (int i = 6; i <= 16; i++)  add(1'b0, (i == 16) ? 3'd6 : 3'd5, therm(i), 1'b0);
        for (int i = 15; i >= 0; i--)  add(1'b0, (i == 0)  ? 3'd0 : 3'd6, therm(i), (i == 0));
        add(1'b0, 3'd0, 16'h0000, 1'b0);   // seq_done is a single pulse
        add(1'b0, 3'd0, 16'h0000, 1'b0);   // idle without flick

        // Reset state.
        #2;
        check("reset_state", 3'd0, 16'h0000, 1'b0);
        @(negedge div_clk);
        rst = 1'b0;
        step("idle_no_flick", 1'b0, 3'd0, 16'h0000, 1'b0);

        // Table-driven full sequence.
        n_cmp++;
        if (vecs.size() != 59) begin
            n_fail++;
            $display("FAIL table_len: got %0d, want 59", vecs.size());
        end
        for (int k = 0; k < vecs.size(); k++)
            step($sformatf("full_seq_edge%0d", k + 1), vecs[k].flick, vecs[k].st, vecs[k].lamps, vecs[k].done);

        // Asynchronous reset mid ST_ON_15 with lamps 03FF.
        start_seq("start_rst");
        advance_to("reach_on15_3ff", 3'd5, 16'h03FF);
        #2 rst = 1'b1;
        #1 check("async_rst", 3'd0, 16'h0000, 1'b0);
        @(negedge div_clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("post_rst_idle", 1'b0, 3'd0, 16'h0000, 1'b0);

        // Kickback at 003F in ST_ON_10.
        start_seq("start_kb_low");
        advance_to("reach_on10_1f", 3'd3, 16'h001F);
        step("kb_low_edge", 1'b1, 3'd2, 16'h003F, 1'b0);
        for (int i = 5; i >= 0; i--) step("kb_low_off", 1'b0, (i == 0) ? 3'd3 : 3'd2, therm(i), 1'b0);
        step("kb_low_restart", 1'b0, 3'd3, 16'h0001, 1'b0);

        // Kickback at 07FF in ST_ON_10: back to zero, not ST_OFF_5.
        advance_to("reach_on10_3ff", 3'd3, 16'h03FF);
        step("kb_mid_edge", 1'b1, 3'd2, 16'h07FF, 1'b0);
        for (int i = 10; i >= 0; i--) step("kb_mid_off", 1'b0, (i == 0) ? 3'd3 : 3'd2, therm(i), 1'b0);

        // Kickback at 07FF in ST_ON_15.
        advance_to("reach_on15_3ff_b", 3'd5, 16'h03FF);
        step("kb_on15_edge", 1'b1, 3'd4, 16'h07FF, 1'b0);
        for (int i = 10; i >= 5; i--) step("kb_on15_off", 1'b0, (i == 5) ? 3'd5 : 3'd4, therm(i), 1'b0);
        step("kb_on15_resume", 1'b0, 3'd5, 16'h003F, 1'b0);
        advance_to("finish_seq", 3'd0, 16'h0000);

        // flick held high: endless kickback between ST_ON_10 and ST_OFF_0.
        begin
            logic [15:0] max_l = 16'h0000;
            bit          any_done = 0;
            bit          bad_st = 0;
            flick = 1'b1;
            for (int i = 0; i < 200; i++) begin
                @(posedge div_clk);
                @(negedge div_clk);
                if (lamps > max_l) max_l = lamps;
                if (seq_done) any_done = 1;
                if (cur_st > 3'd3) bad_st = 1;
            end
            n_cmp++;
            if (max_l !== 16'h003F) begin
                n_fail++;
                $display("FAIL held_flick_peak: got %h, want 003f", max_l);
            end
            n_cmp++;
            if (any_done || bad_st) begin
                n_fail++;
                $display("FAIL held_flick_loop: got done_seen=%0d bad_state=%0d, want 0 0", any_done, bad_st);
            end
            flick = 1'b0;
        end

        // Illegal state 7 recovers to idle on the next edge.
        force dut.cur_st = 3'd7;
        #1 release dut.cur_st;
        @(posedge div_clk);
        @(negedge div_clk);
        check("illegal_state", 3'd0, 16'h0000, 1'b0);
        step("illegal_then_idle", 1'b0, 3'd0, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
